// File: rtl/cascaded_down_timer.sv
// cascaded_down_timer
//  Loadable down-counting timer made of NUM_DIGITS cascaded DIGIT_W-bit digits
//  with a single-cycle borrow ripple. Counts a loaded value to zero, pulses done
//  on reaching zero and borrow on a decrement taken at zero.
//  Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   en         global enable; 0 freezes state and suppresses pulses
//   ld         load din (priority over decr)
//   decr       decrement request
//   din        load value (W bits)
//   count      current count (registered)
//   digit_brw  per-digit borrow-out of this cycle's decrement (registered)
//   borrow     pulse: decrement taken at count==0 (registered)
//   done       pulse: count reached 0 by decrement (registered)
//   zero       combinational count==0
module cascaded_down_timer #(
    parameter int unsigned DIGIT_W     = 2,
    parameter int unsigned NUM_DIGITS  = 3,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          ld,
    input  logic                          decr,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] din,
    output logic [DIGIT_W*NUM_DIGITS-1:0] count,
    output logic [NUM_DIGITS-1:0]         digit_brw,
    output logic                          borrow,
    output logic                          done,
    output logic                          zero
);

    localparam int unsigned W = DIGIT_W * NUM_DIGITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [W-1:0]        reload_val, reload_nxt;
    logic [W-1:0]        count_nxt;
    logic [NUM_DIGITS-1:0] brw_nxt;
    logic                borrow_nxt, done_nxt;

    logic [W-1:0]          dec_val;
    logic [NUM_DIGITS-1:0] dec_brw;

    // Borrow ripple: digit 0 always takes a borrow-in; each digit passes one on
    // only when it was zero (and therefore wraps).
    always_comb begin : dec_chain
        logic               b;
        logic [DIGIT_W-1:0] d;
        dec_val = '0;
        dec_brw = '0;
        b       = 1'b1;
        d       = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            d = count[i*DIGIT_W +: DIGIT_W];
            dec_val[i*DIGIT_W +: DIGIT_W] = d - DIGIT_W'(b);
            dec_brw[i] = b && (d == '0);
            b = dec_brw[i];
        end
    end

    // Next state, next count and next pulse values.
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        reload_nxt = reload_val;
        brw_nxt    = '0;
        borrow_nxt = 1'b0;
        done_nxt   = 1'b0;
        if (en) begin
            if (ld) begin
                count_nxt  = din;
                reload_nxt = din;
                state_nxt  = (din != '0) ? RUN : EXPIRED;
            end else if (decr) begin
                case (state)
                    IDLE: begin
                    end
                    RUN: begin
                        count_nxt = dec_val;
                        brw_nxt   = dec_brw;
                        if (count == W'(1)) begin
                            state_nxt = EXPIRED;
                            done_nxt  = 1'b1;
                        end
                    end
                    EXPIRED: begin
                        borrow_nxt = 1'b1;
                        brw_nxt    = '1;
                        if (AUTO_RELOAD) begin
                            count_nxt = reload_val;
                            if (reload_val != '0) begin
                                state_nxt = RUN;
                            end else begin
                                done_nxt = 1'b1;
                            end
                        end else begin
                            count_nxt = '1;
                            state_nxt = RUN;
                        end
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            reload_val <= '0;
            digit_brw  <= '0;
            borrow     <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            reload_val <= reload_nxt;
            digit_brw  <= brw_nxt;
            borrow     <= borrow_nxt;
            done       <= done_nxt;
        end
    end

    assign zero = (count == '0);

endmodule

// File: tb/tb_cascaded_down_timer.sv
// Self-checking bench for cascaded_down_timer: two instances (wrap and
// auto-reload) share stimulus; an arithmetic model predicts every output.
module tb_cascaded_down_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, ld = 1'b0, decr = 1'b0;
    logic [5:0] din = '0;

    logic [5:0] d_cnt    [2];
    logic [2:0] d_brw    [2];
    logic       d_borrow [2];
    logic       d_done   [2];
    logic       d_zero   [2];

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    cascaded_down_timer #(.DIGIT_W(2), .NUM_DIGITS(3), .AUTO_RELOAD(1'b0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .ld(ld), .decr(decr), .din(din),
        .count(d_cnt[0]), .digit_brw(d_brw[0]), .borrow(d_borrow[0]),
        .done(d_done[0]), .zero(d_zero[0]));

    cascaded_down_timer #(.DIGIT_W(2), .NUM_DIGITS(3), .AUTO_RELOAD(1'b1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .ld(ld), .decr(decr), .din(din),
        .count(d_cnt[1]), .digit_brw(d_brw[1]), .borrow(d_borrow[1]),
        .done(d_done[1]), .zero(d_zero[1]));

    // Model: a timer is "armed" once loaded since reset; at zero it is expired.
    logic [5:0] m_cnt [2];
    logic [5:0] m_rl  [2];
    bit         m_arm [2];
    logic [2:0] m_brw [2];
    bit         m_borrow [2];
    bit         m_done [2];

    logic [5:0] nc, nrl;
    logic [2:0] nbr;
    bit         narm, nb, nd;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < 2; a++) begin
                m_cnt[a] <= '0; m_rl[a] <= '0; m_arm[a] <= 1'b0;
                m_brw[a] <= '0; m_borrow[a] <= 1'b0; m_done[a] <= 1'b0;
            end
        end else begin
            for (int a = 0; a < 2; a++) begin
                nc = m_cnt[a]; nrl = m_rl[a]; narm = m_arm[a];
                nbr = '0; nb = 1'b0; nd = 1'b0;
                if (en) begin
                    if (ld) begin
                        nc = din; nrl = din; narm = 1'b1;
                    end else if (decr && m_arm[a]) begin
                        if (m_cnt[a] != 0) begin
                            // digit i borrows out iff count is a multiple of 4^(i+1)
                            for (int i = 0; i < 3; i++)
                                nbr[i] = (int'(m_cnt[a]) % (1 << (2 * (i + 1)))) == 0;
                            nc = m_cnt[a] - 6'd1;
                            nd = (nc == 0);
                        end else begin
                            nb = 1'b1; nbr = 3'b111;
                            if (a == 1) begin
                                nc = m_rl[a]; nd = (m_rl[a] == 0);
                            end else begin
                                nc = 6'd63;
                            end
                        end
                    end
                end
                m_cnt[a] <= nc; m_rl[a] <= nrl; m_arm[a] <= narm;
                m_brw[a] <= nbr; m_borrow[a] <= nb; m_done[a] <= nd;
            end
        end
    end

    task automatic check(input string name, input int a, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0d, expected %0d at %0t", name, a, act, exp, $time);
        end
    endtask

    // Compare process: every falling edge, all outputs of both instances.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int a = 0; a < 2; a++) begin
                check("count",     a, int'(d_cnt[a]),    int'(m_cnt[a]));
                check("digit_brw", a, int'(d_brw[a]),    int'(m_brw[a]));
                check("borrow",    a, int'(d_borrow[a]), int'(m_borrow[a]));
                check("done",      a, int'(d_done[a]),   int'(m_done[a]));
                check("zero",      a, int'(d_zero[a]),   int'(m_cnt[a] == 0));
            end
        end
    end

    // Apply one cycle of inputs just after a rising edge; return 1 ns after the next.
    task automatic drive(input bit e, input bit l, input bit d, input logic [5:0] v);
        en = e; ld = l; decr = d; din = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset
        #12;
        chk_on = 1'b1;
        check("rst_count", 0, int'(d_cnt[0]), 0);
        @(posedge clk); #1; rst = 1'b0;

        // decr in IDLE is ignored
        repeat (3) drive(1, 0, 1, 6'd0);
        check("idle_count", 0, int'(d_cnt[0]), 0);
        check("idle_borrow", 1, int'(d_borrow[1]), 0);

        // load 3, count down to zero
        drive(1, 1, 0, 6'd3);
        drive(1, 0, 1, 6'd0); check("dn_2", 0, int'(d_cnt[0]), 2);
        drive(1, 0, 1, 6'd0); check("dn_1", 0, int'(d_cnt[0]), 1);
        drive(1, 0, 1, 6'd0);
        check("dn_0", 0, int'(d_cnt[0]), 0);
        check("dn_done", 0, int'(d_done[0]), 1);
        check("dn_zero", 1, int'(d_zero[1]), 1);

        // decrement from zero: wrap vs reload of last value (3)
        drive(1, 0, 1, 6'd0);
        check("wrap_count", 0, int'(d_cnt[0]), 63);
        check("wrap_brw", 0, int'(d_brw[0]), 7);
        check("wrap_borrow", 0, int'(d_borrow[0]), 1);
        check("rl_count", 1, int'(d_cnt[1]), 3);
        check("rl_done", 1, int'(d_done[1]), 0);

        // 4 -> 3: digit0 wraps 0->3, digit1 1->0
        drive(1, 1, 0, 6'd4);
        drive(1, 0, 1, 6'd0);
        check("rip_count", 0, int'(d_cnt[0]), 3);
        check("rip_brw", 0, int'(d_brw[0]), 1);

        // auto-reload with 2, then with 0
        drive(1, 1, 0, 6'd2);
        drive(1, 0, 1, 6'd0);
        drive(1, 0, 1, 6'd0); check("ar_done", 1, int'(d_done[1]), 1);
        drive(1, 0, 1, 6'd0);
        check("ar_count", 1, int'(d_cnt[1]), 2);
        check("ar_borrow", 1, int'(d_borrow[1]), 1);
        drive(1, 1, 0, 6'd0);
        drive(1, 0, 1, 6'd0);
        check("ar0_count", 1, int'(d_cnt[1]), 0);
        check("ar0_borrow", 1, int'(d_borrow[1]), 1);
        check("ar0_done", 1, int'(d_done[1]), 1);

        // ld wins over decr; en=0 freezes
        drive(1, 1, 1, 6'd9); check("lddec", 0, int'(d_cnt[0]), 9);
        drive(0, 0, 1, 6'd0);
        check("hold_count", 0, int'(d_cnt[0]), 9);
        check("hold_brw", 0, int'(d_brw[0]), 0);

        // async reset mid-count
        drive(1, 1, 0, 6'd6);
        drive(1, 0, 1, 6'd0); check("pre_rst", 0, int'(d_cnt[0]), 5);
        #2 rst = 1'b1;
        #1 check("async_rst", 0, int'(d_cnt[0]), 0);
        @(posedge clk); #1; rst = 1'b0;
        repeat (2) drive(1, 0, 1, 6'd0);
        check("post_rst_idle", 0, int'(d_cnt[0]), 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                drive(1, 0, 1, 6'd0);
                rst = 1'b0;
            end else begin
                drive(($urandom % 8) != 0, ($urandom % 10) == 0, ($urandom % 4) != 0,
                      ($urandom % 4 == 0) ? 6'($urandom % 4) : 6'($urandom % 64));
            end
        end

        @(negedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
